// File: rtl/eva_age_tracker_if.sv
// eva_age_tracker_if: cache access events in, per-line ages and hit/evict/update_EVA pulses out
interface eva_age_tracker_if #(
  parameter int k = 3
);
  logic access_valid;
  logic access_hit;
  logic [4:0] access_addr;
  logic [32*k-1:0] age_1D;
  logic evict_data;
  logic [4:0] evict_addr;
  logic hit_data;
  logic [4:0] hit_addr;
  logic update_EVA;
  logic [31:0] classificationBit;
  modport master (
    output access_valid, access_hit, access_addr,
    input age_1D, evict_data, evict_addr, hit_data, hit_addr, update_EVA, classificationBit
  );
  modport slave (
    input access_valid, access_hit, access_addr,
    output age_1D, evict_data, evict_addr, hit_data, hit_addr, update_EVA, classificationBit
  );
endinterface

// File: rtl/eva_age_tracker.sv
// eva_age_tracker: 32-line age tracker with registered hit/evict/update_EVA pulses; EVA_CLASSIFY_EN adds per-line reuse flags
module eva_age_tracker #(
  parameter int k = 3,
  parameter int j = 2,
  parameter int A = 2,
  parameter int accessCtrWidth = 13
) (
  input logic clk,
  input logic rst,
  eva_age_tracker_if.slave bus
);
  logic [k-1:0] age [32];
  logic [j-1:0] gran_cnt;
  logic [accessCtrWidth-1:0] access_cnt;
  logic stage_valid, hit_q, evict_q, update_q;
  logic [4:0] stage_addr;
  logic tick;
  assign tick = gran_cnt == j'(A - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_valid <= 1'b0;
      hit_q <= 1'b0;
      evict_q <= 1'b0;
      update_q <= 1'b0;
      stage_addr <= '0;
      gran_cnt <= '0;
      access_cnt <= '0;
      for (int i = 0; i < 32; i++) age[i] <= '0;
    end else begin
      stage_valid <= bus.access_valid;
      hit_q <= bus.access_valid & bus.access_hit;
      evict_q <= bus.access_valid & ~bus.access_hit;
      if (bus.access_valid) stage_addr <= bus.access_addr;
      update_q <= stage_valid & (&access_cnt);
      if (stage_valid) begin
        gran_cnt <= tick ? '0 : gran_cnt + 1'b1;
        access_cnt <= access_cnt + 1'b1;
        // the touched line's clear wins over the tick; saturated ages hold
        for (int i = 0; i < 32; i++)
          age[i] <= 5'(i) == stage_addr ? '0 : (tick && ~&age[i]) ? age[i] + 1'b1 : age[i];
      end
    end
  end
  for (genvar g = 0; g < 32; g++) assign bus.age_1D[g*k +: k] = age[g];
  assign bus.hit_data = hit_q;
  assign bus.evict_data = evict_q;
  assign bus.hit_addr = stage_addr;
  assign bus.evict_addr = stage_addr;
  assign bus.update_EVA = update_q;
`ifdef EVA_CLASSIFY_EN
  logic [31:0] cls;
  always_ff @(posedge clk) begin
    if (!rst) cls <= '0;
    else if (stage_valid) cls[stage_addr] <= hit_q;
  end
  assign bus.classificationBit = cls;
`else
  assign bus.classificationBit = '0;
`endif
endmodule

// File: tb/tb_eva_age_tracker.sv
// tb_eva_age_tracker: randomized scoreboard bench for eva_age_tracker against a per-line age model
module tb_eva_age_tracker;
  localparam int K = 3;
  localparam int A = 2;
  localparam int EPOCH = 8192;
  localparam int MAX_AGE = 7;
`ifdef EVA_CLASSIFY_EN
  localparam bit CLS = 1'b1;
`else
  localparam bit CLS = 1'b0;
`endif
  typedef struct packed {
    logic hit;
    logic [4:0] addr;
    logic [32*K-1:0] ages;
    logic [31:0] cls;
    logic upd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_q = 1'b0;
  logic exp_upd = 1'b0;
  int tests = 0;
  int fails = 0;
  int upd_seen = 0;
  int n_acc = 0;
  int ages_m [32];
  bit cls_m [32];
  exp_t q [$];
  always #5 clk = ~clk;
  eva_age_tracker_if #(.k(K)) bus ();
  eva_age_tracker #(.k(K), .j(2), .A(A), .accessCtrWidth(13)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [32*K-1:0] pack_ages();
    logic [32*K-1:0] v;
    for (int i = 0; i < 32; i++) v[i*K +: K] = K'(ages_m[i]);
    return v;
  endfunction
  function automatic logic [31:0] pack_cls();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = cls_m[i];
    return v;
  endfunction
  task automatic model_clear();
    n_acc = 0;
    for (int i = 0; i < 32; i++) begin
      ages_m[i] = 0;
      cls_m[i] = 1'b0;
    end
  endtask
  // issue one cycle of stimulus; a valid access is applied to the model in program order
  task automatic acc(input bit v, input bit h, input int a);
    exp_t e;
    bit tick;
    @(posedge clk);
    #1;
    bus.access_valid = v;
    bus.access_hit = h;
    bus.access_addr = 5'(a);
    if (v && rst) begin
      e.hit = h;
      e.addr = 5'(a);
      e.ages = pack_ages();
      e.cls = pack_cls();
      e.upd = ((n_acc + 1) % EPOCH) == 0;
      tick = ((n_acc + 1) % A) == 0;
      for (int i = 0; i < 32; i++)
        if (i == a) ages_m[i] = 0;
        else if (tick) ages_m[i] = (ages_m[i] + 1 > MAX_AGE) ? MAX_AGE : ages_m[i] + 1;
      if (CLS) cls_m[a] = h;
      n_acc++;
      q.push_back(e);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) acc(1'b0, 1'b0, 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.access_valid = 1'b1;
    bus.access_hit = 1'b1;
    bus.access_addr = 5'd7;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.access_valid = 1'b0;
    model_clear();
  endtask
  always @(posedge clk) rst_q <= rst;
  always @(negedge clk) begin
    if (!rst_q) begin
      chk("rst_pulses", {bus.hit_data, bus.evict_data, bus.update_EVA}, 3'b000);
      chk("rst_ages", bus.age_1D, '0);
      chk("rst_cls", bus.classificationBit, '0);
      exp_upd = 1'b0;
    end else begin
      chk("update_EVA", bus.update_EVA, exp_upd);
      exp_upd = 1'b0;
      if (bus.hit_data || bus.evict_data) begin
        if (q.size() == 0) chk("spurious_pulse", {bus.hit_data, bus.evict_data}, 2'b00);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind", {bus.hit_data, bus.evict_data}, {e.hit, !e.hit});
          chk("pulse_addr", e.hit ? bus.hit_addr : bus.evict_addr, e.addr);
          chk("pre_ages", bus.age_1D, e.ages);
          chk("pre_cls", bus.classificationBit, e.cls);
          exp_upd = e.upd;
        end
      end
    end
    if (bus.update_EVA) upd_seen++;
  end
  initial begin
    int u0;
    bus.access_valid = 1'b0;
    bus.access_hit = 1'b0;
    bus.access_addr = '0;
    model_clear();
    do_reset();
    repeat (4) acc(1'b1, 1'b1, 5);
    idle(2);
    @(negedge clk);
    chk("gran_line0", bus.age_1D[0*K +: K], 3'd2);
    chk("gran_line5", bus.age_1D[5*K +: K], 3'd0);
    repeat (20) acc(1'b1, 1'b1, 0);
    idle(2);
    @(negedge clk);
    chk("sat_line1", bus.age_1D[1*K +: K], 3'd7);
    chk("sat_line31", bus.age_1D[31*K +: K], 3'd7);
    chk("sat_line0", bus.age_1D[0*K +: K], 3'd0);
    do_reset();
    repeat (8) acc(1'b1, 1'b1, 0);
    acc(1'b1, 1'b0, 3);
    idle(1);
    @(negedge clk);
    chk("evict_pulse", bus.evict_data, 1'b1);
    chk("evict_addr", bus.evict_addr, 5'd3);
    chk("evict_pre_age", bus.age_1D[3*K +: K], 3'd4);
    idle(1);
    @(negedge clk);
    chk("evict_post_age", bus.age_1D[3*K +: K], 3'd0);
    do_reset();
    acc(1'b1, 1'b1, 9);
    idle(2);
    @(negedge clk);
    chk("cls_set", bus.classificationBit[9], CLS);
    acc(1'b1, 1'b0, 9);
    idle(1);
    @(negedge clk);
    chk("cls_during_evict", bus.classificationBit[9], CLS);
    idle(1);
    @(negedge clk);
    chk("cls_cleared", bus.classificationBit[9], 1'b0);
    do_reset();
    u0 = upd_seen;
    for (int n = 0; n < EPOCH; n++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      acc(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
    end
    idle(3);
    chk("epoch_pulses", upd_seen - u0, 1);
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      acc($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
    end
    idle(3);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
